// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared single-port memory between instruction fetch and the
// MEM stage, with anti-starvation for fetches, flush discard and access timeout.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush_if,
  input  logic        mem_req_m,
  input  logic        mem_we_m,
  input  logic [31:0] mem_addr_m,
  input  logic [31:0] mem_wdata_m,
  input  logic        ram_rdy,
  input  logic [31:0] ram_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err,
  output logic        busy
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_TOP    = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_INSTR = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic          r_discard;
  logic          r_err;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo;

  logic w_busy;
  logic w_fetch_ok;
  logic w_tmo;
  logic w_done;
  logic w_grant_d;
  logic w_grant_i;

  assign w_busy     = (r_state != S_IDLE);
  assign w_fetch_ok = if_req & ~flush_if;
  // Timeout fires on the TIMEOUT-th port cycle that still has no ram_rdy.
  assign w_tmo      = w_busy & ~ram_rdy & (r_tmo == TMO_LAST);
  assign w_done     = w_busy & (ram_rdy | w_tmo);

  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = r_addr;
    ram_wdata = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    if_valid  = 1'b0;
    if_rdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_fetch_ok && (r_starve == STARVE_TOP)) begin
          w_grant_i = 1'b1;
          w_next    = S_INSTR;
        end else if (mem_req_m) begin
          w_grant_d = 1'b1;
          w_next    = S_DATA;
        end else if (w_fetch_ok) begin
          w_grant_i = 1'b1;
          w_next    = S_INSTR;
        end
      end
      S_DATA: begin
        ram_en    = 1'b1;
        ram_we    = r_we;
        ram_wdata = r_wdata;
        mem_valid = w_done;
        mem_rdata = (ram_rdy && !r_we) ? ram_rdata : '0;
        if (w_done) w_next = S_IDLE;
      end
      S_INSTR: begin
        ram_en   = 1'b1;
        // A discarded fetch still drains the port, just without a valid.
        if_valid = w_done & ~r_discard;
        if_rdata = (ram_rdy && !r_discard) ? ram_rdata : '0;
        if (w_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_grant_d) begin
      r_addr  <= mem_addr_m;
      r_we    <= mem_we_m;
      r_wdata <= mem_wdata_m;
    end else if (w_grant_i) begin
      r_addr  <= if_addr;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_starve <= '0;
    else if (w_grant_i)
      r_starve <= '0;
    else if (w_grant_d && if_req && (r_starve != STARVE_TOP))
      r_starve <= r_starve + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmo <= '0;
    else if (w_grant_d || w_grant_i)
      r_tmo <= '0;
    else if (w_busy && !ram_rdy && (r_tmo != TMO_TOP))
      r_tmo <= r_tmo + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_discard <= 1'b0;
    else if ((r_state == S_INSTR) && (w_next != S_INSTR))
      r_discard <= 1'b0;
    else if ((r_state == S_INSTR) && flush_if)
      r_discard <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_err <= 1'b0;
    else if (w_tmo) r_err <= 1'b1;
  end

  assign stall_mem = mem_req_m & ~mem_valid;
  assign stall_if  = (if_req & ~if_valid) | ((r_state == S_INSTR) & r_discard);
  assign err       = r_err;
  assign busy      = w_busy;

endmodule
